// File: rtl/phy_link_sequencer.sv
// PHY bring-up and link monitor: pulses the PHY hard reset, writes one config
// register through the MDIO master, then polls link/speed status forever.
module phy_link_sequencer #(
    parameter logic [4:0]  PHY_ADDR          = 5'd0,
    parameter int unsigned RESET_CYCLES      = 1_250_000,
    parameter int unsigned POST_RESET_CYCLES = 6_250_000,
    parameter logic [4:0]  CFG_REG           = 5'd0,
    parameter logic [15:0] CFG_DATA          = 16'h1200,
    parameter logic [4:0]  STATUS_REG        = 5'd1,
    parameter logic [4:0]  SPEED_REG         = 5'd17,
    parameter int unsigned POLL_CYCLES       = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES    = 65_536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    output logic        phy_rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        status_change,
    output logic [7:0]  timeout_count
);

    localparam int unsigned MAX_AB = (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int unsigned MAX_CD = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        RST_ASSERT, RST_WAIT, CFG_REQ, CFG_RSP, POLL_WAIT,
        STAT_REQ, STAT_RSP, SPD_REQ, SPD_RSP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phy_rst_n_q, phy_rst_n_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             cmd_write_q, cmd_write_d;
    logic [4:0]       cmd_reg_addr_q, cmd_reg_addr_d;
    logic [15:0]      cmd_wdata_q, cmd_wdata_d;
    logic             link_up_q, link_up_d;
    logic [1:0]       speed_q, speed_d;
    logic             full_duplex_q, full_duplex_d;
    logic             status_change_q, status_change_d;
    logic [7:0]       timeout_count_q, timeout_count_d;

    logic cmd_accept;
    logic in_rsp;
    logic timed_out;
    logic unused_rdata;

    assign cmd_accept   = cmd_valid_q && cmd_ready;
    assign in_rsp       = (state_q == CFG_RSP) || (state_q == STAT_RSP) || (state_q == SPD_RSP);
    // A response arriving on the final counted cycle still wins over the timeout.
    assign timed_out    = in_rsp && (cnt_q == TO_LAST) && !rsp_valid;
    assign unused_rdata = ^{rsp_rdata[12], rsp_rdata[10:3], rsp_rdata[1:0]};

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + CNT_W'(1);
        cmd_valid_d     = 1'b0;
        cmd_write_d     = cmd_write_q;
        cmd_reg_addr_d  = cmd_reg_addr_q;
        cmd_wdata_d     = cmd_wdata_q;
        link_up_d       = link_up_q;
        speed_d         = speed_q;
        full_duplex_d   = full_duplex_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            RST_ASSERT: if (cnt_q == RST_LAST) state_d = RST_WAIT;
            RST_WAIT: begin
                if (cnt_q == POST_LAST) begin
                    state_d        = CFG_REQ;
                    cmd_write_d    = 1'b1;
                    cmd_reg_addr_d = CFG_REG;
                    cmd_wdata_d    = CFG_DATA;
                end
            end
            CFG_REQ, STAT_REQ, SPD_REQ: begin
                if (cmd_accept) begin
                    state_d = (state_q == CFG_REQ)  ? CFG_RSP :
                              (state_q == STAT_REQ) ? STAT_RSP : SPD_RSP;
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            CFG_RSP: if (rsp_valid || timed_out) state_d = POLL_WAIT;
            POLL_WAIT: begin
                // Restart is only taken here so an issued MDIO command always completes.
                if (restart) begin
                    state_d   = RST_ASSERT;
                    link_up_d = 1'b0;
                end else if (cnt_q == POLL_LAST) begin
                    state_d        = STAT_REQ;
                    cmd_write_d    = 1'b0;
                    cmd_reg_addr_d = STATUS_REG;
                    cmd_wdata_d    = 16'h0000;
                end
            end
            STAT_RSP: begin
                if (rsp_valid) begin
                    if (rsp_rdata[2]) begin
                        state_d        = SPD_REQ;
                        cmd_write_d    = 1'b0;
                        cmd_reg_addr_d = SPEED_REG;
                        cmd_wdata_d    = 16'h0000;
                    end else begin
                        state_d   = POLL_WAIT;
                        link_up_d = 1'b0;
                    end
                end else if (timed_out) begin
                    state_d = POLL_WAIT;
                end
            end
            SPD_RSP: begin
                if (rsp_valid) begin
                    state_d = POLL_WAIT;
                    if (!rsp_rdata[11] || rsp_rdata[15:14] == 2'b11) begin
                        link_up_d = 1'b0;
                    end else begin
                        link_up_d     = 1'b1;
                        speed_d       = rsp_rdata[15:14];
                        full_duplex_d = rsp_rdata[13];
                    end
                end else if (timed_out) begin
                    state_d = POLL_WAIT;
                end
            end
            default: state_d = RST_ASSERT;
        endcase

        if (timed_out && timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
        if (state_d != state_q) cnt_d = '0;

        status_change_d = {link_up_d, speed_d, full_duplex_d} != {link_up_q, speed_q, full_duplex_q};
        phy_rst_n_d     = (state_d != RST_ASSERT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RST_ASSERT;
            cnt_q           <= '0;
            phy_rst_n_q     <= 1'b0;
            cmd_valid_q     <= 1'b0;
            cmd_write_q     <= 1'b0;
            cmd_reg_addr_q  <= 5'd0;
            cmd_wdata_q     <= 16'h0000;
            link_up_q       <= 1'b0;
            speed_q         <= 2'b00;
            full_duplex_q   <= 1'b0;
            status_change_q <= 1'b0;
            timeout_count_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            phy_rst_n_q     <= phy_rst_n_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_write_q     <= cmd_write_d;
            cmd_reg_addr_q  <= cmd_reg_addr_d;
            cmd_wdata_q     <= cmd_wdata_d;
            link_up_q       <= link_up_d;
            speed_q         <= speed_d;
            full_duplex_q   <= full_duplex_d;
            status_change_q <= status_change_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign phy_rst_n     = phy_rst_n_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_write     = cmd_write_q;
    assign cmd_phy_addr  = PHY_ADDR;
    assign cmd_reg_addr  = cmd_reg_addr_q;
    assign cmd_wdata     = cmd_wdata_q;
    assign link_up       = link_up_q;
    assign speed         = speed_q;
    assign full_duplex   = full_duplex_q;
    assign status_change = status_change_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_phy_link_sequencer.sv
// Directed and randomized bench for phy_link_sequencer with an MDIO responder
// and a rule-level model of the decoded link status.
module tb_phy_link_sequencer;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst, restart, cmd_ready, rsp_valid;
    logic [15:0] rsp_rdata;
    logic        phy_rst_n, cmd_valid, cmd_write, link_up, full_duplex, status_change;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  speed;
    logic [7:0]  timeout_count;

    int checks = 0;
    int errors = 0;

    // Model of what the outputs should currently show.
    bit       m_link;
    bit [1:0] m_speed;
    bit       m_dup;
    int       m_to;

    always #4 clk = ~clk;

    phy_link_sequencer #(
        .RESET_CYCLES(8), .POST_RESET_CYCLES(4), .POLL_CYCLES(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .phy_rst_n(phy_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .link_up(link_up), .speed(speed),
        .full_duplex(full_duplex), .status_change(status_change), .timeout_count(timeout_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_phy_rst_n"}, phy_rst_n, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_write"}, cmd_write, 0);
        check({tag, "_cmd_reg"}, cmd_reg_addr, 0);
        check({tag, "_cmd_wdata"}, cmd_wdata, 0);
        check({tag, "_link_up"}, link_up, 0);
        check({tag, "_speed"}, speed, 0);
        check({tag, "_duplex"}, full_duplex, 0);
        check({tag, "_status_change"}, status_change, 0);
        check({tag, "_timeout_count"}, timeout_count, 0);
    endtask

    // Move the model to a new decoded status and compare outputs plus change pulse.
    task automatic apply(input bit l, input bit [1:0] s, input bit d, input string tag);
        bit changed;
        changed = ({l, s, d} != {m_link, m_speed, m_dup});
        m_link  = l;
        m_speed = s;
        m_dup   = d;
        check({tag, "_link_up"}, link_up, m_link);
        check({tag, "_speed"}, speed, m_speed);
        check({tag, "_duplex"}, full_duplex, m_dup);
        check({tag, "_status_change"}, status_change, changed);
    endtask

    task automatic issue(input bit wr, input bit [4:0] reg_a, input bit [15:0] wd, input int rd);
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("cmd_valid_seen", cmd_valid, 1);
        for (int i = 0; i <= rd; i++) begin
            check("cmd_valid_held", cmd_valid, 1);
            check("cmd_write", cmd_write, wr);
            check("cmd_phy_addr", cmd_phy_addr, 0);
            check("cmd_reg_addr", cmd_reg_addr, reg_a);
            check("cmd_wdata", cmd_wdata, wd);
            if (i < rd) step();
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("cmd_valid_drop", cmd_valid, 0);
    endtask

    // Response lands on the k-th clock edge after the accepting edge.
    task automatic respond(input int k, input logic [15:0] data);
        repeat (k - 1) step();
        rsp_valid = 1'b1;
        rsp_rdata = data;
        step();
        rsp_valid = 1'b0;
        rsp_rdata = 16'($urandom);
    endtask

    task automatic poll_round(input logic [15:0] bmsr, input logic [15:0] physr, input int rd, input int kd);
        issue(0, 5'd1, 16'h0, rd);
        respond(kd, bmsr);
        if (!bmsr[2]) begin
            apply(0, m_speed, m_dup, "stat_down");
        end else begin
            apply(m_link, m_speed, m_dup, "stat_up");
            issue(0, 5'd17, 16'h0, rd);
            respond(kd, physr);
            if (!physr[11] || physr[15:14] == 2'b11) apply(0, m_speed, m_dup, "spd_bad");
            else apply(1, physr[15:14], physr[13], "spd_ok");
        end
    endtask

    // Current sample is the first cycle with phy_rst_n low.
    task automatic reset_seq(input string tag);
        int low;
        int gap;
        low = 1;
        step();
        while (phy_rst_n === 1'b0 && low < 100) begin
            low++;
            step();
        end
        check({tag, "_phy_rst_low_cycles"}, low, 8);
        gap = 0;
        while (cmd_valid !== 1'b1 && gap < 100) begin
            step();
            gap++;
        end
        check({tag, "_post_reset_gap_ge4"}, (gap >= 4), 1);
        issue(1, 5'd0, 16'h1200, 2);
        respond(3, 16'($urandom));
        apply(m_link, m_speed, m_dup, {tag, "_cfg_done"});
    endtask

    task automatic do_timeout();
        int exp_to;
        issue(0, 5'd1, 16'h0, 0);
        exp_to = (m_to > 255) ? 255 : m_to;
        repeat (TO - 1) step();
        check("timeout_not_yet", timeout_count, exp_to);
        step();
        m_to++;
        exp_to = (m_to > 255) ? 255 : m_to;
        check("timeout_count", timeout_count, exp_to);
        apply(m_link, m_speed, m_dup, "timeout_hold");
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] p;
        rst = 1'b1; restart = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 16'h0;
        m_link = 0; m_speed = 0; m_dup = 0; m_to = 0;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        reset_seq("boot");

        poll_round(16'h0004, 16'hA800, 0, 2);
        poll_round(16'h0004, 16'hA800, 1, 1);
        poll_round(16'h0000, 16'hA800, 0, 1);
        poll_round(16'h0004, 16'h6000, 0, 3);
        poll_round(16'h0004, 16'hA800, 0, 1);
        poll_round(16'h0004, 16'hC800, 2, 2);
        poll_round(16'h0004, 16'h4800, 0, TO);
        check("late_rsp_no_timeout", timeout_count, 0);

        for (int i = 0; i < 24; i++) begin
            b = 16'($urandom);
            p = 16'($urandom);
            p[11] = ($urandom_range(0, 3) != 0);
            poll_round(b, p, $urandom_range(0, 3), $urandom_range(1, 6));
        end

        for (int i = 0; i < 300; i++) do_timeout();
        poll_round(16'h0004, 16'h2800, 0, 1);

        poll_round(16'h0004, 16'hA800, 20, 1);

        issue(0, 5'd1, 16'h0, 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_ignored_rsp", phy_rst_n, 1);
        respond(2, 16'h0004);
        apply(m_link, m_speed, m_dup, "restart_ignored_stat");
        issue(0, 5'd17, 16'h0, 0);
        respond(1, 16'h6800);
        apply(1, 2'b01, 1, "restart_ignored_spd");

        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_phy_rst_n", phy_rst_n, 0);
        apply(0, m_speed, m_dup, "restart");
        reset_seq("restart");

        poll_round(16'h0004, 16'hA800, 0, 1);
        issue(0, 5'd1, 16'h0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check_reset("midread");
        rst = 1'b0;
        m_link = 0; m_speed = 0; m_dup = 0; m_to = 0;
        reset_seq("midread");
        poll_round(16'h0004, 16'h0800, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
